masked_share_encoder: RTL and testbench
=======================================

Name: masked_share_encoder

Overview:
- Masking-side transmitter that produces the shared inputs consumed by the DOM gadgets.
- Accepts an unmasked WIDTH-bit word plus fresh randomness and splits it into NSHARES Boolean shares.
- Emits the shares serially, one per handshake, so no two shares of a word share a cycle on the output bus.
- Sits between the unmasked input source and the masked datapath's share-loading logic.

Parameters:
- WIDTH, 8: bits per word and per share.
- NSHARES, 3: share count; legal range 2..8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source offers in_data.
- in_ready  out  1  encoder can accept a word; high exactly in IDLE.
- in_data  in  WIDTH  unmasked word.
- rnd  in  (NSHARES-1)*WIDTH  fresh randomness; slice i is rnd[i*WIDTH +: WIDTH].
- rnd_valid  in  1  randomness is fresh this cycle.
- sh_valid  out  1  sh_data holds a share.
- sh_ready  in  1  sink accepts the share.
- sh_data  out  WIDTH  current share.
- sh_idx  out  $clog2(NSHARES)  index of the current share.
- sh_last  out  1  current share is index NSHARES-1.

Behaviour:
- Reset is asynchronous and active-low; clock is clk, reset is rst_n.
- Reset state: state=IDLE, share registers=0, idx=0, sh_valid=0, sh_data=0, sh_idx=0, sh_last=0.
- in_ready=1 in IDLE, including while rst_n is low; no flop updates while rst_n is low.
- Accept condition: in_valid && rnd_valid && in_ready at a rising edge.
  - in_valid alone with rnd_valid=0 is not accepted; in_data and rnd may change freely.
- On accept:
  - s[i] <= rnd slice i, for i < NSHARES-1.
  - s[NSHARES-1] <= in_data ^ (XOR of all rnd slices).
  - idx <= 0; state <= SEND.
- SEND state:
  - sh_valid=1, sh_data=s[idx], sh_idx=idx, sh_last=(idx==NSHARES-1), in_ready=0.
  - On sh_valid && sh_ready: if idx < NSHARES-1, idx increments; otherwise state <= IDLE and idx <= 0.
- Backpressure: with sh_ready=0, sh_data, sh_idx and sh_last hold stable.
- Shares are emitted in order 0..NSHARES-1; no reordering and no skipping.
- Latency: accept at edge k gives the first share valid in the cycle after edge k.
- Throughput: NSHARES+1 cycles per word with sh_ready held high. The mandatory IDLE cycle means no accept occurs in the same cycle as the last share handshake.
- Invariant: the XOR of all emitted shares equals the accepted in_data.
- Outputs are registered state only; no combinational path from in_data or rnd to sh_data.
- Reset mid-SEND: the word is dropped, all registers return to reset values, and any partial share sequence is abandoned.
- Simultaneous in_valid during SEND: ignored, since in_ready=0.

Optional Feature:
- Macro: SHARE_ZEROIZE_EN.
- Defined:
  - s[idx] is cleared to 0 on its handshake.
  - sh_data is forced to 0 whenever sh_valid=0.
  - Returning to IDLE leaves all share registers at 0.
- Undefined:
  - Share registers hold their values until the next accept.
  - sh_data = s[idx] regardless of sh_valid.

Decomposition:
- Package masking_pkg holds:
  - the NSHARES default;
  - the share-index width localparam;
  - the enum state_t {IDLE, SEND};
  - a function xor_reduce_slices(rnd) returning the WIDTH-bit XOR of all slices.
- One sub-module, share_split: combinational WIDTH/NSHARES splitter producing the NSHARES share vector from in_data and rnd. It is instantiated once; the encoder registers its outputs on accept.

Test Plan:
- Basic split (WIDTH=8, NSHARES=3): in_data=0xA5, rnd slice0=0x0F, slice1=0x3C, sh_ready=1 -> shares 0x0F(idx0), 0x3C(idx1), 0x96(idx2, sh_last=1) on consecutive cycles; in_ready returns to 1 one cycle after the last share.
- Randomness gating: in_valid=1, rnd_valid=0 for 4 cycles, then rnd_valid=1 -> no accept and sh_valid=0 for those 4 cycles; accept on the 5th edge; first share on the next cycle.
- Backpressure: sh_ready=0 for 3 cycles while idx=1 -> sh_data=0x3C, sh_idx=1, sh_valid=1 stable throughout; 0x96 follows one cycle after sh_ready rises.
- Reset mid-SEND: assert rst_n=0 after share 0 -> sh_valid=0, sh_data=0, sh_idx=0 immediately (async); after release, in_ready=1 and the next word (0x00, rnd=0xFF/0xFF) yields 0xFF, 0xFF, 0x00.
- Throughput: 3 words back-to-back, in_valid/rnd_valid=1, sh_ready=1 -> exactly 4 cycles per word; XOR of each share triple matches the source word.
- SHARE_ZEROIZE_EN defined: after the 0xA5 sequence, sh_data=0 in IDLE and the internal share registers read 0. Undefined: sh_data holds 0x0F (s[0]) in IDLE.

Source files
------------

// File: rtl/masking_pkg.sv
// rtl/masking_pkg.sv - shared types, defaults and slice-XOR helper for the share encoder.
package masking_pkg;

  localparam int NSHARES_DEF = 3;
  localparam int WIDTH_DEF   = 8;
  localparam int IDX_W       = $clog2(NSHARES_DEF);

  // Helper operates on a fixed maximum footprint: up to 7 randomness slices of up to 64 bits.
  localparam int MAX_W      = 64;
  localparam int MAX_SLICES = 7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic logic [MAX_W-1:0] xor_reduce_slices(
    input logic [MAX_SLICES*MAX_W-1:0] rnd,
    input int                          nslices,
    input int                          width
  );
    logic [MAX_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_SLICES; i++) begin
      if (i < nslices) begin
        for (int b = 0; b < MAX_W; b++) begin
          if (b < width) acc[b] = acc[b] ^ rnd[i*width+b];
        end
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/share_split.sv
// rtl/share_split.sv - combinational Boolean split of one word into NSHARES shares.
module share_split
  import masking_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NSHARES = NSHARES_DEF
) (
  input  logic [WIDTH-1:0]             in_data,
  input  logic [(NSHARES-1)*WIDTH-1:0] rnd,
  output logic [NSHARES*WIDTH-1:0]     shares
);

  logic [MAX_SLICES*MAX_W-1:0] rnd_pad;
  logic [WIDTH-1:0]            mix;

  always_comb begin
    rnd_pad = '0;
    rnd_pad[(NSHARES-1)*WIDTH-1:0] = rnd;
    mix = WIDTH'(xor_reduce_slices(rnd_pad, NSHARES - 1, WIDTH));
  end

  // Low slices are the raw randomness; the top share absorbs the data.
  assign shares = {in_data ^ mix, rnd};

endmodule

// File: rtl/masked_share_encoder.sv
// rtl/masked_share_encoder.sv - registers a split word and streams its shares one per handshake.
// Optional SHARE_ZEROIZE_EN: clear each share after it is sent and blank sh_data while idle.
module masked_share_encoder
  import masking_pkg::*;
#(
  parameter  int WIDTH   = WIDTH_DEF,
  parameter  int NSHARES = NSHARES_DEF,
  localparam int IW      = $clog2(NSHARES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [(NSHARES-1)*WIDTH-1:0] rnd,
  input  logic                         rnd_valid,
  output logic                         sh_valid,
  input  logic                         sh_ready,
  output logic [WIDTH-1:0]             sh_data,
  output logic [IW-1:0]                sh_idx,
  output logic                         sh_last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NSHARES - 1);

  state_t                            state_q, state_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic [NSHARES-1:0][WIDTH-1:0]     s_q, s_d;
  logic [NSHARES*WIDTH-1:0]          split;
  logic                              accept, hs;

  share_split #(.WIDTH(WIDTH), .NSHARES(NSHARES)) u_split (
    .in_data (in_data),
    .rnd     (rnd),
    .shares  (split)
  );

  assign accept = in_valid && rnd_valid && in_ready;
  assign hs     = sh_valid && sh_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    s_d     = s_q;
    if (accept) begin
      s_d     = split;
      idx_d   = '0;
      state_d = SEND;
    end else if (hs) begin
`ifdef SHARE_ZEROIZE_EN
      s_d[idx_q] = '0;
`endif
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign sh_valid = (state_q == SEND);
  assign sh_idx   = idx_q;
  assign sh_last  = sh_valid && (idx_q == LAST_IDX);

`ifdef SHARE_ZEROIZE_EN
  assign sh_data = sh_valid ? s_q[idx_q] : '0;
`else
  assign sh_data = s_q[idx_q];
`endif

endmodule

// File: tb/tb_masked_share_encoder.sv
// tb/tb_masked_share_encoder.sv - randomized and directed checks of masked_share_encoder against a queue model.
// Honours SHARE_ZEROIZE_EN for the idle-output expectations.
module tb_masked_share_encoder;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int IW = $clog2(N);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready, rnd_valid;
  logic [W-1:0]       in_data;
  logic [(N-1)*W-1:0] rnd;
  logic               sh_valid, sh_ready, sh_last;
  logic [W-1:0]       sh_data;
  logic [IW-1:0]      sh_idx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_log[$];
  logic [W-1:0] dut_log[$];
  int           last_cyc[$];
  logic [W-1:0] last_s0;

  masked_share_encoder #(.WIDTH(W), .NSHARES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .sh_valid  (sh_valid),
    .sh_ready  (sh_ready),
    .sh_data   (sh_data),
    .sh_idx    (sh_idx),
    .sh_last   (sh_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: a word is taken only while no shares are pending; one pending share retires per ready edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      last_s0 = '0;
    end else if (exp_q.size() == 0) begin
      if (in_valid && rnd_valid) begin
        logic [W-1:0] x;
        x = in_data;
        for (int i = 0; i < N - 1; i++) begin
          exp_q.push_back(rnd[i*W +: W]);
          x = x ^ rnd[i*W +: W];
        end
        exp_q.push_back(x);
        last_s0 = exp_q[0];
        acc_log.push_back(in_data);
      end
    end else if (sh_ready) begin
      void'(exp_q.pop_front());
    end
  end

  function automatic logic [W-1:0] idle_data();
`ifdef SHARE_ZEROIZE_EN
    return '0;
`else
    return last_s0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_sh_valid", 32'(sh_valid), 0);
      chk("rst_sh_data", 32'(sh_data), 0);
    end else begin
      chk("sh_valid", 32'(sh_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      if (exp_q.size() != 0) begin
        chk("sh_data", 32'(sh_data), 32'(exp_q[0]));
        chk("sh_idx", 32'(sh_idx), 32'(N - exp_q.size()));
        chk("sh_last", 32'(sh_last), 32'(exp_q.size() == 1));
        if (sh_valid && sh_ready) begin
          dut_log.push_back(sh_data);
          if (sh_last) last_cyc.push_back(cyc);
        end
      end else begin
        chk("idle_sh_data", 32'(sh_data), 32'(idle_data()));
        chk("idle_sh_idx", 32'(sh_idx), 0);
        chk("idle_sh_last", 32'(sh_last), 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(in_ready && !sh_valid) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("wait_idle_timeout", 32'(in_ready && !sh_valid), 1);
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic [(N-1)*W-1:0] r);
    wait_idle(20);
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    in_data   = d;
    rnd       = r;
    step();
    in_valid  = 1'b0;
    rnd_valid = 1'b0;
  endtask

  task automatic chk_log3(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c);
    chk({name, "_count"}, 32'(dut_log.size()), 3);
    if (dut_log.size() == 3) begin
      chk({name, "_s0"}, 32'(dut_log[0]), 32'(a));
      chk({name, "_s1"}, 32'(dut_log[1]), 32'(b));
      chk({name, "_s2"}, 32'(dut_log[2]), 32'(c));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; sh_ready = 1'b0;
    in_data = '0; rnd = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Basic split
    sh_ready = 1'b1;
    dut_log.delete();
    send_word(8'hA5, {8'h3C, 8'h0F});
    chk("basic_first_valid", 32'(sh_valid), 1);
    wait_idle(10);
    chk_log3("basic", 8'h0F, 8'h3C, 8'h96);
`ifdef SHARE_ZEROIZE_EN
    chk("basic_idle_data", 32'(sh_data), 32'h00);
    for (int i = 0; i < N; i++) chk("zeroized_reg", 32'(dut.s_q[i]), 0);
`else
    chk("basic_idle_data", 32'(sh_data), 32'h0F);
`endif

    // Randomness gating
    dut_log.delete();
    in_valid = 1'b1; rnd_valid = 1'b0; in_data = 8'h5A; rnd = {8'h11, 8'h22};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gate_no_accept", 32'(sh_valid), 0);
    end
    rnd_valid = 1'b1;
    step();
    in_valid = 1'b0; rnd_valid = 1'b0;
    chk("gate_first_valid", 32'(sh_valid), 1);
    chk("gate_first_data", 32'(sh_data), 32'h22);
    wait_idle(10);
    chk_log3("gate", 8'h22, 8'h11, 8'h69);

    // Backpressure on share 1
    dut_log.delete();
    send_word(8'hA5, {8'h3C, 8'h0F});
    step();
    sh_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 32'(sh_valid), 1);
      chk("bp_data", 32'(sh_data), 32'h3C);
      chk("bp_idx", 32'(sh_idx), 1);
    end
    sh_ready = 1'b1;
    step();
    chk("bp_after_data", 32'(sh_data), 32'h96);
    chk("bp_after_last", 32'(sh_last), 1);
    wait_idle(10);

    // Reset mid-SEND
    send_word(8'hA5, {8'h3C, 8'h0F});
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(sh_valid), 0);
    chk("arst_data", 32'(sh_data), 0);
    chk("arst_idx", 32'(sh_idx), 0);
    chk("arst_ready", 32'(in_ready), 1);
    step(); step();
    rst_n = 1'b1;
    dut_log.delete();
    send_word(8'h00, {8'hFF, 8'hFF});
    wait_idle(10);
    chk_log3("post_rst", 8'hFF, 8'hFF, 8'h00);

    // Back-to-back throughput
    dut_log.delete(); last_cyc.delete(); acc_log.delete();
    in_valid = 1'b1; rnd_valid = 1'b1; sh_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = W'($urandom);
      rnd = (N-1)*W'($urandom);
      step();
    end
    in_valid = 1'b0; rnd_valid = 1'b0;
    wait_idle(10);
    chk("tp_words", 32'(acc_log.size()), 3);
    chk("tp_lasts", 32'(last_cyc.size()), 3);
    if (last_cyc.size() == 3) begin
      chk("tp_gap0", 32'(last_cyc[1] - last_cyc[0]), 4);
      chk("tp_gap1", 32'(last_cyc[2] - last_cyc[1]), 4);
    end
    if (dut_log.size() == 9 && acc_log.size() == 3) begin
      for (int k = 0; k < 3; k++)
        chk("tp_xor", 32'(dut_log[3*k] ^ dut_log[3*k+1] ^ dut_log[3*k+2]), 32'(acc_log[k]));
    end else begin
      chk("tp_share_count", 32'(dut_log.size()), 9);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rnd_valid = ($urandom_range(0, 3) != 0);
      sh_ready  = ($urandom_range(0, 2) != 0);
      in_data   = W'($urandom);
      rnd       = (N-1)*W'($urandom);
      step();
    end
    in_valid = 1'b0; rnd_valid = 1'b0; sh_ready = 1'b1;
    wait_idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
